seq_op_sequencer: RTL and testbench

//   Request/response front-end directly upstream of seq_top. Accepts one op request
//   (MUL/DIV/REM + operands + tag) via valid/ready and registers it. Drives seq_top
//   a/b/start and waits for finish. Returns a tagged, status-coded result via valid/ready.

---
 rtl/seq_op_sequencer.sv | 164 ++++++++++++++++
 tb/tb_seq_op_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_op_sequencer.sv
// rtl/seq_op_sequencer.sv - tagged op request/response front-end driving the seq_top engine
module seq_op_sequencer #(
    parameter int WidthA        = 32,
    parameter int WidthB        = 32,
    parameter int IdWidth       = 4,
    parameter int TimeoutCycles = 128
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [1:0]                req_op_i,
    input  logic [WidthA-1:0]         req_a_i,
    input  logic [WidthB-1:0]         req_b_i,
    input  logic [IdWidth-1:0]        req_id_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [WidthA+WidthB-1:0]  rsp_data_o,
    output logic [IdWidth-1:0]        rsp_id_o,
    output logic [1:0]                rsp_err_o,
    output logic [WidthA-1:0]         a_o,
    output logic [WidthB-1:0]         b_o,
    output logic                      start_o,
    input  logic [WidthA+WidthB-1:0]  c_i,
    input  logic [WidthA-1:0]         q_i,
    input  logic [WidthB-1:0]         r_i,
    input  logic                      finish_i
);

    localparam int WidthC = WidthA + WidthB;
    localparam int CntW   = $clog2(TimeoutCycles + 1);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_REM = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        BUSY  = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q;
    logic [WidthA-1:0]   a_q;
    logic [WidthB-1:0]   b_q;
    logic [IdWidth-1:0]  id_q;
    logic [WidthC-1:0]   data_q;
    logic [1:0]          err_q;
    logic [CntW-1:0]     cnt_q;

    logic accept;
    logic div_zero;
    logic local_resp;
    logic timeout;

    assign accept     = req_valid_i && (state_q == IDLE);
    assign div_zero   = ((req_op_i == OP_DIV) || (req_op_i == OP_REM)) && (req_b_i == '0);
    assign local_resp = (req_op_i == OP_ILL) || div_zero;
    // cnt_q counts completed BUSY cycles, so the last allowed one sees TimeoutCycles-1
    assign timeout    = (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = local_resp ? RESP : ISSUE;
                end
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                if (finish_i || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            data_q <= '0;
            err_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q   <= req_op_i;
                        a_q    <= req_a_i;
                        b_q    <= req_b_i;
                        id_q   <= req_id_i;
                        data_q <= '0;
                        err_q  <= ERR_OK;
                        if (req_op_i == OP_ILL) begin
                            err_q <= ERR_ILLEGAL;
                        end else if (div_zero) begin
                            err_q <= ERR_DIV0;
                            if (req_op_i == OP_DIV) begin
                                data_q <= {{WidthB{1'b0}}, {WidthA{1'b1}}};
                            end else begin
                                data_q <= {{WidthB{1'b0}}, req_a_i};
                            end
                        end
                    end
                end
                ISSUE: cnt_q <= '0;
                BUSY: begin
                    // finish has priority over a coincident timeout
                    if (finish_i) begin
                        err_q <= ERR_OK;
                        case (op_q)
                            OP_MUL:  data_q <= c_i;
                            OP_DIV:  data_q <= {{WidthB{1'b0}}, q_i};
                            OP_REM:  data_q <= {{WidthA{1'b0}}, r_i};
                            default: data_q <= '0;
                        endcase
                    end else if (timeout) begin
                        data_q <= '0;
                        err_q  <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign start_o     = (state_q == ISSUE);
    assign rsp_data_o  = data_q;
    assign rsp_id_o    = id_q;
    assign rsp_err_o   = err_q;
    assign a_o         = a_q;
    assign b_o         = b_q;

endmodule

// File: tb/tb_seq_op_sequencer.sv
// tb/tb_seq_op_sequencer.sv - scoreboard bench for seq_op_sequencer with a behavioural engine
module tb_seq_op_sequencer;

    logic        clk;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_id;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_id;
    logic [1:0]  rsp_err;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic        start;
    logic [63:0] c_i;
    logic [31:0] q_i;
    logic [31:0] r_i;
    logic        finish;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  id;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   start_count = 0;
    int   eng_mode = 0;
    int   eng_lat  = 3;
    int   eng_cnt  = 0;

    seq_op_sequencer #(
        .WidthA(32), .WidthB(32), .IdWidth(4), .TimeoutCycles(40)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b), .req_id_i(req_id),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_id_o(rsp_id), .rsp_err_o(rsp_err),
        .a_o(a_o), .b_o(b_o), .start_o(start),
        .c_i(c_i), .q_i(q_i), .r_i(r_i), .finish_i(finish)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Engine: mode 0 finishes eng_lat cycles after start, 1 never finishes, 2 pulses finish during ISSUE only
    always @(posedge clk) begin
        #1;
        if (!rst_ni) begin
            eng_cnt = 0;
            finish  = 1'b0;
        end else begin
            finish = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    finish = 1'b1;
                    c_i = {32'b0, a_o} * {32'b0, b_o};
                    q_i = (b_o != 0) ? a_o / b_o : 32'hFFFF_FFFF;
                    r_i = (b_o != 0) ? a_o % b_o : a_o;
                end
            end
            if (start) begin
                start_count++;
                if (eng_mode == 0) eng_cnt = eng_lat;
                else if (eng_mode == 2) finish = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_ni && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got response id %0d, expected none", rsp_id);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] id, input logic [63:0] ed, input logic [1:0] ee,
                          input int exp_steps, input int hold);
        int   steps;
        int   s0;
        exp_t e;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        e.data = ed;
        e.id   = id;
        e.err  = ee;
        sb.push_back(e);
        s0 = start_count;
        req_valid = 1'b1;
        req_op = op;
        req_a  = a;
        req_b  = b;
        req_id = id;
        step();
        req_valid = 1'b0;
        req_a = 32'hDEAD_BEEF;
        req_b = 32'h0;
        steps = 0;
        while (!rsp_valid && steps < 200) begin
            step();
            steps++;
        end
        chk("rsp_latency", 64'(steps), 64'(exp_steps));
        chk("start_pulses", 64'(start_count - s0), (exp_steps == 0) ? 64'd0 : 64'd1);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_op = 2'b00;
            req_a  = 32'd1;
            req_b  = 32'd1;
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_data", rsp_data, ed);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("idle_after_hs", {62'b0, rsp_valid, req_ready}, 64'd1);
    endtask

    initial begin
        rst_ni    = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_id    = '0;
        rsp_ready = 1'b0;
        c_i = '0;
        q_i = '0;
        r_i = '0;
        finish = 1'b0;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_start", 64'(start), 64'd0);
        chk("reset_data", rsp_data, 64'd0);
        repeat (2) step();
        rst_ni = 1'b1;
        step();

        do_req(2'b00, 32'd7,   32'd6, 4'd3,  64'd42, 2'b00, 4, 0);
        do_req(2'b01, 32'd100, 32'd7, 4'd5,  64'd14, 2'b00, 4, 0);
        do_req(2'b10, 32'd100, 32'd7, 4'd6,  64'd2,  2'b00, 4, 0);
        do_req(2'b01, 32'd5,   32'd0, 4'd9,  64'h0000_0000_FFFF_FFFF, 2'b01, 0, 0);
        do_req(2'b10, 32'd5,   32'd0, 4'd10, 64'd5,  2'b01, 0, 0);
        do_req(2'b11, 32'd8,   32'd2, 4'd11, 64'd0,  2'b10, 0, 0);
        do_req(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 64'hFFFF_FFFE_0000_0001, 2'b00, 4, 5);
        eng_lat = 1;
        do_req(2'b10, 32'd1000, 32'd33, 4'd1, 64'd10, 2'b00, 2, 0);

        eng_mode = 1;
        do_req(2'b00, 32'd3, 32'd4, 4'd7, 64'd0, 2'b11, 41, 0);
        eng_mode = 2;
        do_req(2'b01, 32'd9, 32'd3, 4'd8, 64'd0, 2'b11, 41, 0);

        eng_mode = 1;
        req_valid = 1'b1;
        req_op = 2'b00;
        req_a  = 32'd3;
        req_b  = 32'd4;
        req_id = 4'd2;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_busy_start", 64'(start), 64'd0);
        chk("rst_busy_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy_ab", {a_o, b_o}, 64'd0);
        chk("rst_busy_rsp", {rsp_data[59:0], rsp_id}, 64'd0);
        chk("rst_busy_err", 64'(rsp_err), 64'd0);
        step();
        step();
        rst_ni = 1'b1;
        eng_mode = 0;
        eng_lat = 3;
        step();
        do_req(2'b00, 32'd7, 32'd6, 4'd12, 64'd42, 2'b00, 4, 0);

        repeat (3) step();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
